// File: rtl/hack_rom_loader.sv
// Byte-stream program loader for the Hack instruction ROM.
// Parses MAGIC, LEN_HI, LEN_LO, N words (high byte first) and an XOR checksum.
// Words are written to ROM addresses 0..N-1. The CPU is held in reset until a
// frame has been loaded and its checksum matches.
module hack_rom_loader #(
    parameter int          ADDR_W = 15,
    parameter logic [7:0]  MAGIC  = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    // Largest legal word count; N is compared against it at full width.
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [7:0]          chk_q, chk_d;
    logic [7:0]          hi_q, hi_d;
    logic                rx_ready_q, rx_ready_d;
    logic                rom_we_q, rom_we_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [15:0]         rom_wdata_q, rom_wdata_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic [15:0]         len_new;
    logic [ADDR_W:0]     cnt_inc;

    assign accept  = rx_valid && rx_ready_q;
    assign len_new = {len_q[15:8], rx_data};
    // Counter is one bit wider than the address so N == 2^ADDR_W is reachable.
    assign cnt_inc = cnt_q + 1'b1;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            chk_q       <= '0;
            hi_q        <= '0;
            rx_ready_q  <= 1'b0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            chk_q       <= chk_d;
            hi_q        <= hi_d;
            rx_ready_q  <= rx_ready_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Frame parser: next state and next output values, advancing only on accepted bytes.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        chk_d       = chk_q;
        hi_d        = hi_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
        cpu_reset_d = cpu_reset_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;

        case (state_q)
            // Idle, done and error all hunt for MAGIC; anything else is dropped.
            S_IDLE, S_DONE, S_ERROR: begin
                if (accept && rx_data == MAGIC) begin
                    state_d     = S_LEN_HI;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    cpu_reset_d = 1'b1;
                    chk_d       = '0;
                    cnt_d       = '0;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d   = {rx_data, len_q[7:0]};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = len_new;
                    if ({16'd0, len_new} > CAPACITY) begin
                        state_d = S_ERROR;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end else if (len_new == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    chk_d   = chk_q ^ rx_data;
                    state_d = S_DATA_LO;
                end
            end
            // The ROM write is staged here so the strobe appears during WRITE.
            S_DATA_LO: begin
                if (accept) begin
                    chk_d       = chk_q ^ rx_data;
                    rom_we_d    = 1'b1;
                    rom_addr_d  = cnt_q[ADDR_W-1:0];
                    rom_wdata_d = {hi_q, rx_data};
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                cnt_d = cnt_inc;
                if (32'(cnt_inc) == {16'd0, len_q}) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_DATA_HI;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (rx_data == chk_q) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Ready is dropped only for the single write cycle.
    always_comb begin
        rx_ready_d = (state_d != S_WRITE);
    end

    assign rx_ready  = rx_ready_q;
    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_wdata = rom_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
